// File: rtl/pkt_buffer.sv
// pkt_buffer: single-packet byte store with a 32-bit big-endian read / byte-lane write port.
// Optional PKTBUF_ZERO_PAD_EN: bytes at or past pkt_len, or any byte outside HELD, read as zero.
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif

module pkt_buffer #(
  parameter int DEPTH = 2048,
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             sram_ce_i,
  input  logic             sram_we_i,
  input  logic [`ADDR_BUS] sram_addr_i,
  input  logic [3:0]       sram_sel_i,
  input  logic [`DATA_BUS] sram_data_i,
  output logic [`DATA_BUS] sram_data_o,
  output logic             pkt_ready,
  output logic [LEN_W-1:0] pkt_len,
  input  logic             pkt_release,
  output logic             overflow
);
  // state | meaning
  // EMPTY | no packet, waiting for the first byte
  // FILL  | receiving bytes
  // HELD  | packet stored, ingress closed, parser may rewrite

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW = $bits(sram_addr_i) + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [XW-1:0]    DEPTH_X = XW'(DEPTH);

  typedef enum logic [1:0] {EMPTY, FILL, HELD} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic             in_ready_q, in_ready_d;
  logic             pkt_ready_q, pkt_ready_d;
  logic             overflow_q, overflow_d;
  logic [`DATA_BUS] rdata_q, rdata_d;

  logic [7:0] mem [DEPTH];

  logic          accept, room, rd_en, wr_en;
  logic [XW-1:0] lane_idx [4];
  logic [3:0]    lane_in;
  logic [3:0]    lane_vis;

  assign accept = in_valid && in_ready_q;
  assign room   = (wr_ptr_q < DEPTH_L);
  assign rd_en  = sram_ce_i && !sram_we_i;
  assign wr_en  = sram_ce_i && sram_we_i && (state_q == HELD);

  // One extra address bit so a+3 never wraps back into the array.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_idx[i]  = {1'b0, sram_addr_i} + XW'(i);
      lane_in[3-i] = (lane_idx[i] < DEPTH_X);
`ifdef PKTBUF_ZERO_PAD_EN
      lane_vis[3-i] = lane_in[3-i] && (state_q == HELD) && (lane_idx[i] < XW'(pkt_len_q));
`else
      lane_vis[3-i] = lane_in[3-i];
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pkt_len_d   = pkt_len_q;
    pkt_ready_d = pkt_ready_q;
    overflow_d  = overflow_q;
    rdata_d     = rdata_q;

    if (accept) begin
      if (room) wr_ptr_d = wr_ptr_q + LEN_W'(1);
      else      overflow_d = 1'b1;
      if (in_last) begin
        state_d     = HELD;
        pkt_len_d   = room ? wr_ptr_q + LEN_W'(1) : wr_ptr_q;
        pkt_ready_d = 1'b1;
      end else if (state_q == EMPTY) begin
        state_d = FILL;
      end
    end else if ((state_q == HELD) && pkt_release) begin
      state_d     = EMPTY;
      wr_ptr_d    = '0;
      pkt_len_d   = '0;
      overflow_d  = 1'b0;
      pkt_ready_d = 1'b0;
    end

    in_ready_d = (state_d != HELD);

    if (rd_en) begin
      for (int i = 0; i < 4; i++) begin
        rdata_d[31-8*i -: 8] = lane_vis[3-i] ? mem[lane_idx[i][AW-1:0]] : 8'h00;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= '0;
      pkt_len_q   <= '0;
      in_ready_q  <= 1'b0;
      pkt_ready_q <= 1'b0;
      overflow_q  <= 1'b0;
      rdata_q     <= `ZERO_WORD;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pkt_len_q   <= pkt_len_d;
      in_ready_q  <= in_ready_d;
      pkt_ready_q <= pkt_ready_d;
      overflow_q  <= overflow_d;
      rdata_q     <= rdata_d;
    end
  end

  // Storage keeps its contents across reset; ingress and parser writes are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (accept && room) mem[wr_ptr_q[AW-1:0]] <= in_data;
    if (wr_en && sram_sel_i[3] && lane_in[3]) mem[lane_idx[0][AW-1:0]] <= sram_data_i[31:24];
    if (wr_en && sram_sel_i[2] && lane_in[2]) mem[lane_idx[1][AW-1:0]] <= sram_data_i[23:16];
    if (wr_en && sram_sel_i[1] && lane_in[1]) mem[lane_idx[2][AW-1:0]] <= sram_data_i[15:8];
    if (wr_en && sram_sel_i[0] && lane_in[0]) mem[lane_idx[3][AW-1:0]] <= sram_data_i[7:0];
  end

  assign in_ready    = in_ready_q;
  assign pkt_ready   = pkt_ready_q;
  assign pkt_len     = pkt_len_q;
  assign overflow    = overflow_q;
  assign sram_data_o = rdata_q;

endmodule

// File: doc/pkt_buffer.md
Name: pkt_buffer

Overview:
- Byte-addressed packet store and SRAM-style responder for the header parser.
- Ingress side accepts one packet as a byte stream (valid/ready/last) and holds it.
- Parser side serves 32-bit big-endian reads at arbitrary byte addresses with one-cycle latency.
- Byte-lane writes from the parser side let a later rewrite stage modify headers in place before the packet is released.

Parameters:
- DEPTH, 2048: packet storage capacity in bytes.
- LEN_W, 12: width of pkt_len; must satisfy 2^LEN_W > DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high (`TRUE).
- in_valid  in  1  ingress byte valid.
- in_ready  out  1  ingress byte accept.
- in_data  in  8  ingress byte.
- in_last  in  1  last byte of packet.
- sram_ce_i  in  1  parser-side access enable.
- sram_we_i  in  1  parser-side write (1) / read (0).
- sram_addr_i  in  `ADDR_BUS  byte address.
- sram_sel_i  in  4  byte-lane select; bit 3 = byte addr+0.
- sram_data_i  in  `DATA_BUS  write data.
- sram_data_o  out  `DATA_BUS  read data.
- pkt_ready  out  1  packet fully loaded and held.
- pkt_len  out  LEN_W  stored byte count.
- pkt_release  in  1  one-cycle pulse: discard the packet and reopen ingress.
- overflow  out  1  sticky flag: packet exceeded DEPTH.

Behaviour:
- Reset values: in_ready=0, sram_data_o=`ZERO_WORD, pkt_ready=0, pkt_len=0, overflow=0, wr_ptr=0, state=EMPTY.
- Memory contents are not cleared by reset.
- In the first cycle after reset deasserts, state is EMPTY and in_ready=1.
- States:
  - EMPTY: waiting for the first byte.
  - FILL: receiving bytes.
  - HELD: packet stored.
- Ingress handshake:
  - A byte transfers when in_valid && in_ready.
  - in_ready=1 in EMPTY and FILL; in_ready=0 in HELD.
- EMPTY→FILL on the first accepted byte without in_last.
- EMPTY→HELD on the first accepted byte with in_last.
- FILL→HELD on an accepted byte with in_last.
- HELD→EMPTY on pkt_release. On that transition: wr_ptr=0, pkt_len=0, overflow=0, pkt_ready=0.
- pkt_release in EMPTY or FILL is ignored.
- Each accepted byte with wr_ptr < DEPTH is written to mem[wr_ptr]; wr_ptr increments.
- Each accepted byte with wr_ptr == DEPTH is dropped and overflow is set. in_ready stays 1, so the stream drains to in_last.
- On entering HELD: pkt_len=wr_ptr (capped at DEPTH) and pkt_ready=1, both registered, in the cycle after the last byte.
- Read (ce=1, we=0), sampled at edge k:
  - sram_data_o at edge k+1 = {mem[a], mem[a+1], mem[a+2], mem[a+3]}, with mem[a] in [31:24].
  - Any byte with index >= DEPTH reads 8'h00. There is no wrap-around.
  - Reads are allowed in any state.
- Write (ce=1, we=1):
  - Accepted only in HELD.
  - Byte a+i is written from sram_data_i[31-8i -: 8] when sram_sel_i[3-i]=1 and a+i < DEPTH.
  - pkt_len is unchanged.
  - sram_data_o holds its previous value.
  - Writes in EMPTY or FILL are ignored.
- When ce=0, sram_data_o holds its previous value.
- Read immediately after a write to the same bytes returns the new data.
- Ingress writes and parser writes never coincide, because parser writes are accepted only in HELD.
- Reset mid-fill or mid-read returns to EMPTY immediately. Partial packet state is discarded.

Optional Feature:
- Macro: PKTBUF_ZERO_PAD_EN.
- Defined: in reads, any byte with index >= pkt_len (and any byte in EMPTY or FILL) returns 8'h00. Parser tag fetches past a short packet therefore never match stale data.
- Undefined: only indices >= DEPTH read as zero; stale bytes from earlier packets are visible.

Test Plan:
- Load a 34-byte frame with bytes 12–13 = 08 00 and byte 23 = 11 -> pkt_ready=1 and pkt_len=34 one cycle after last; read addr 12 -> next cycle sram_data_o[31:16]=16'h0800; read addr 23 -> [31:24]=8'h11.
- With PKTBUF_ZERO_PAD_EN, 34-byte packet held, read addr 32 -> [31:16]=bytes 32–33, [15:0]=16'h0000; without the macro, [15:0] = previous packet's bytes 34–35.
- In HELD, write addr 14, sel 4'b1100, data 32'h4500_FFFF -> read addr 14 returns [31:16]=16'h4500, bytes 16–17 unchanged.
- DEPTH=64, stream 70 bytes -> in_ready=1 throughout, overflow=1, pkt_len=64; read addr 62 -> [15:0]=16'h0000.
- In HELD, drive in_valid=1 -> in_ready=0, no write; pulse pkt_release -> next cycle pkt_ready=0, in_ready=1; second packet loads from address 0.
- Assert rst asynchronously after byte 10 of a fill -> outputs at reset values immediately; after release of rst a fresh 20-byte packet gives pkt_len=20.
